pea_kxk: RTL and testbench
==========================

Name: pea_kxk

Overview:
- Parametrised successor of the 3x3 PE array: K x K convolution over COL adjacent output pixels of one output row.
- Supports runtime stride 1/2, multi-channel accumulation with a programmable channel count, optional ReLU, and a valid/ready handshake on both the input and output streams.
- Sits between the ifm/wgt fetch logic and the ofm writeback.
- Replaces free-running read strobes and external done pulses with internal beat and channel counters.

Parameters:
- K, 3, kernel size (rows and columns); legal 1..7.
- COL, 10, output pixels computed in parallel.
- DWIDTH, 8, signed ifm/wgt element width.
- ACC_WIDTH, 32, signed accumulator/output width per pixel.
- IC_WIDTH, 10, width of the channel-count field.
- IFM_LANES, (COL-1)*2+K, ifm elements per beat (derived; sized for stride 2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- stride  in  1  0 = stride 1, 1 = stride 2; sampled at job start
- relu_en  in  1  clamp negative results to 0; sampled at job start
- cfg_ic  in  IC_WIDTH  input channels minus 1; sampled at job start
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- ifm_row  in  IFM_LANES*DWIDTH  one ifm row segment; lane i at [i*DWIDTH +: DWIDTH]
- wgt_row  in  K*DWIDTH  one kernel row; element c at [c*DWIDTH +: DWIDTH]
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- out_data  out  COL*ACC_WIDTH  pixel x at [x*ACC_WIDTH +: ACC_WIDTH], signed

Behaviour:
- Async reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, all counters, accumulators and pipeline registers 0.
- Job definition: K*(cfg_ic+1) beats, channel-major; within each channel, kernel rows 0..K-1 in order.
- Per beat, pixel x contribution: sum over c=0..K-1 of ifm[x*S+c] * wgt[c], with S=1 or 2.
  - Products are signed DWIDTH x DWIDTH, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
  - With stride 1, lanes at or above (COL-1)+K are ignored.
- Pipeline:
  - Cycle of acceptance: beat products and row sums are registered (stage 1).
  - Following cycle: the stage-1 sum is added into the accumulator.
- State machine:
  - IDLE: in_ready=1. On the first accepted beat, latch stride, relu_en and cfg_ic; clear row_cnt and ic_cnt; go to ACCUM.
  - ACCUM: in_ready=1. Each accepted beat increments row_cnt, wrapping at K-1 and then incrementing ic_cnt. When the beat with row_cnt==K-1 && ic_cnt==cfg_ic is accepted, go to DRAIN.
  - DRAIN: in_ready=0. The final add completes; go to OUT.
  - OUT: out_valid=1; out_data is registered and equals acc, or max(acc,0) if relu_en.
- Latency: out_valid rises exactly 2 cycles after the last beat is accepted.
- Output hold: while out_valid && !out_ready, out_data, out_valid and in_ready=0 are held stable.
- On the out handshake: clear accumulators, deassert out_valid the next cycle, go to IDLE.
- A beat presented in the same cycle as the out handshake is NOT accepted, because in_ready=0 in OUT. It is accepted one cycle later.
- Gaps (in_valid=0) in ACCUM: no state change, and the accumulator is untouched apart from completing the pending stage-1 add.
- cfg_ic=0: single channel, K beats. cfg_ic max: 2^IC_WIDTH channels; counters must not overflow.
- Changes to stride, relu_en or cfg_ic mid-job are ignored until the next IDLE acceptance.
- Reset asserted mid-job: immediate return to reset values. The partial result is discarded and never output.

Decomposition:
- Package pea_pkg holds:
  - state typedef enum {IDLE, ACCUM, DRAIN, OUT};
  - ACC_WIDTH default constant;
  - a sign-extension helper function.
- Sub-module pe_row_mac, instantiated COL times. It takes K ifm and K wgt elements, computes K signed products and their sum, and registers the result (stage 1). Accumulators and control stay in pea_kxk.

Test Plan:
- Reset: hold rstn=0 while driving in_valid=1. Required: in_ready=1, out_valid=0, out_data=0. After release, no output appears without beats.
- K=3, COL=4, stride=0, cfg_ic=0, all ifm=1, all wgt=1, 3 back-to-back beats. Required: every pixel = 9, with out_valid exactly 2 cycles after the 3rd beat is accepted.
- stride=1, ifm lane i = i, wgt=1, cfg_ic=0, 3 beats. Required: pixels = 9, 27, 45, 63.
- Signed inputs, ifm=-128, cfg_ic=1 (6 beats):
  - wgt=-128: required pixels = 294912.
  - wgt=127, relu_en=0: required pixels = -292608.
  - wgt=127, relu_en=1: required pixels = 0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1. Required: out_data stable, in_ready=0, no beat accepted. After the handshake, the next job's first beat is accepted 1 cycle later and its result is unpolluted by the previous job (9 again).
- Reset after 2 of 3 beats, then a full fresh job with all ones. Required: result 9, and no out_valid from the aborted job.

Source files
------------

// File: rtl/pea_pkg.sv
// Shared types and helpers for the K x K PE array.
// Imported by the array top and its per-pixel row MAC.
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  localparam int ACC_WIDTH_DEF = 32;

  // Replicates bit w-1 of v into every bit above it.
  function automatic logic [63:0] sext(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/pe_row_mac.sv
// One output pixel's kernel-row dot product.
// Products and row sum are registered when a beat is accepted.
module pe_row_mac
  import pea_pkg::*;
#(
  parameter int K         = 3,
  parameter int DWIDTH    = 8,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic [K*DWIDTH-1:0]         ifm,
  input  logic [K*DWIDTH-1:0]         wgt,
  output logic signed [ACC_WIDTH-1:0] sum
);

  logic signed [ACC_WIDTH-1:0] sum_d;

  always_comb begin
    logic signed [DWIDTH-1:0]   a;
    logic signed [DWIDTH-1:0]   b;
    logic signed [2*DWIDTH-1:0] p;
    sum_d = '0;
    a     = '0;
    b     = '0;
    p     = '0;
    for (int c = 0; c < K; c++) begin
      a     = ifm[c*DWIDTH +: DWIDTH];
      b     = wgt[c*DWIDTH +: DWIDTH];
      p     = a * b;
      sum_d = sum_d +
        ACC_WIDTH'(sext(64'(unsigned'(p)), 2*DWIDTH));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sum <= '0;
    else if (en)
      sum <= sum_d;
  end

endmodule

// File: rtl/pea_kxk.sv
// K x K convolution over COL adjacent output pixels.
// Multi-channel accumulation, stride 1/2, optional ReLU.
module pea_kxk
  import pea_pkg::*;
#(
  parameter int K         = 3,
  parameter int COL       = 10,
  parameter int DWIDTH    = 8,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int IC_WIDTH  = 10,
  parameter int IFM_LANES = (COL-1)*2+K
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         stride,
  input  logic                         relu_en,
  input  logic [IC_WIDTH-1:0]          cfg_ic,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IFM_LANES*DWIDTH-1:0]  ifm_row,
  input  logic [K*DWIDTH-1:0]          wgt_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COL*ACC_WIDTH-1:0]     out_data
);

  localparam int RW = (K > 1) ? $clog2(K) : 1;

  state_t                state, state_nx;
  logic [RW-1:0]         row_cnt;
  logic [IC_WIDTH-1:0]   ic_cnt;
  logic [IC_WIDTH-1:0]   cfg_ic_q;
  logic                  stride_q;
  logic                  relu_q;
  logic                  v1;

  logic                  accept;
  logic                  eff_stride;
  logic [IC_WIDTH-1:0]   eff_ic;
  logic [RW-1:0]         cur_row;
  logic [IC_WIDTH-1:0]   cur_ic;
  logic                  last;

  logic signed [ACC_WIDTH-1:0] s1     [COL];
  logic signed [ACC_WIDTH-1:0] acc    [COL];
  logic signed [ACC_WIDTH-1:0] acc_nx [COL];

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;

  // The job's first beat uses live config; later beats use the latch.
  assign eff_stride = (state == IDLE) ? stride : stride_q;
  assign eff_ic     = (state == IDLE) ? cfg_ic : cfg_ic_q;
  assign cur_row    = (state == IDLE) ? '0 : row_cnt;
  assign cur_ic     = (state == IDLE) ? '0 : ic_cnt;
  assign last       = (cur_row == RW'(K-1)) && (cur_ic == eff_ic);

  for (genvar x = 0; x < COL; x++) begin : g_px
    logic [K*DWIDTH-1:0] lanes;
    for (genvar c = 0; c < K; c++) begin : g_ln
      assign lanes[c*DWIDTH +: DWIDTH] = eff_stride ?
        ifm_row[(2*x+c)*DWIDTH +: DWIDTH] :
        ifm_row[(x+c)*DWIDTH +: DWIDTH];
    end
    pe_row_mac #(
      .K         (K),
      .DWIDTH    (DWIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
      .clk  (clk),
      .rstn (rstn),
      .en   (accept),
      .ifm  (lanes),
      .wgt  (wgt_row),
      .sum  (s1[x])
    );
  end

  always_comb begin
    for (int x = 0; x < COL; x++)
      acc_nx[x] = v1 ? acc[x] + s1[x] : acc[x];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = last ? DRAIN : ACCUM;
      ACCUM: if (accept && last) state_nx = DRAIN;
      DRAIN: state_nx = OUT;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt  <= '0;
      ic_cnt   <= '0;
      cfg_ic_q <= '0;
      stride_q <= 1'b0;
      relu_q   <= 1'b0;
      v1       <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept && state == IDLE) begin
        cfg_ic_q <= cfg_ic;
        stride_q <= stride;
        relu_q   <= relu_en;
      end
      if (accept) begin
        if (last) begin
          row_cnt <= '0;
          ic_cnt  <= '0;
        end else if (cur_row == RW'(K-1)) begin
          row_cnt <= '0;
          ic_cnt  <= cur_ic + IC_WIDTH'(1);
        end else begin
          row_cnt <= cur_row + RW'(1);
          ic_cnt  <= cur_ic;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
      for (int x = 0; x < COL; x++)
        acc[x] <= '0;
    end else begin
      for (int x = 0; x < COL; x++) begin
        if (state == OUT && out_ready)
          acc[x] <= '0;
        else
          acc[x] <= acc_nx[x];
        if (state == DRAIN)
          out_data[x*ACC_WIDTH +: ACC_WIDTH] <=
            (relu_q && acc_nx[x][ACC_WIDTH-1]) ? '0 : acc_nx[x];
      end
    end
  end

endmodule

// File: tb/tb_pea_kxk.sv
// Scoreboard bench for pea_kxk (K=3, COL=4).
module tb_pea_kxk;

  localparam int K     = 3;
  localparam int COL   = 4;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int ICW   = 10;
  localparam int LANES = (COL-1)*2+K;
  localparam int IFM_W = LANES*DW;
  localparam int WGT_W = K*DW;
  localparam int OUT_W = COL*AW;

  logic             clk = 0;
  logic             rstn;
  logic             stride;
  logic             relu_en;
  logic [ICW-1:0]   cfg_ic;
  logic             in_valid;
  logic             in_ready;
  logic [IFM_W-1:0] ifm_row;
  logic [WGT_W-1:0] wgt_row;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  logic ov_prev = 0;
  logic [OUT_W-1:0] exp_q [$];

  pea_kxk #(
    .K(K), .COL(COL), .DWIDTH(DW), .ACC_WIDTH(AW),
    .IC_WIDTH(ICW), .IFM_LANES(LANES)
  ) dut (
    .clk(clk), .rstn(rstn), .stride(stride),
    .relu_en(relu_en), .cfg_ic(cfg_ic),
    .in_valid(in_valid), .in_ready(in_ready),
    .ifm_row(ifm_row), .wgt_row(wgt_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [OUT_W-1:0] model(
    input logic st, input logic rl, input int nb,
    input logic [IFM_W-1:0] f, input logic [WGT_W-1:0] w
  );
    logic [OUT_W-1:0] r;
    longint s;
    int idx;
    logic signed [DW-1:0] a, b;
    logic [AW-1:0] t;
    r = '0;
    for (int x = 0; x < COL; x++) begin
      s = 0;
      for (int c = 0; c < K; c++) begin
        idx = st ? 2*x+c : x+c;
        a = f[idx*DW +: DW];
        b = w[c*DW +: DW];
        s += longint'(a) * longint'(b);
      end
      s = s * nb;
      t = s[AW-1:0];
      if (rl && t[AW-1]) t = '0;
      r[x*AW +: AW] = t;
    end
    return r;
  endfunction

  function automatic logic [IFM_W-1:0] ifm_const(input int v);
    logic [IFM_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [IFM_W-1:0] ifm_ramp();
    logic [IFM_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(i);
    return r;
  endfunction

  function automatic logic [WGT_W-1:0] wgt_const(input int v);
    logic [WGT_W-1:0] r;
    for (int i = 0; i < K; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  // Scoreboard and latency monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !ov_prev) begin
        checks++;
        if (cyc - acc_cyc != 2) begin
          errors++;
          $display("FAIL latency: got %0d cycles, want 2",
                   cyc - acc_cyc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, want none",
                   out_data);
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL result: got %h, want %h", out_data, e);
          end
        end
      end
      ov_prev = out_valid;
    end else begin
      ov_prev = 0;
    end
  end

  task automatic drive_beat(output int waited);
    logic got;
    in_valid = 1;
    waited = 0;
    forever begin
      got = in_ready;
      @(posedge clk); #1;
      if (got) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got no accept, want accept");
        break;
      end
    end
  endtask

  task automatic run_job(
    input logic st, input logic rl, input int ic,
    input logic [IFM_W-1:0] f, input logic [WGT_W-1:0] w
  );
    int nb;
    int wt;
    nb = K * (ic + 1);
    exp_q.push_back(model(st, rl, nb, f, w));
    stride = st; relu_en = rl; cfg_ic = ICW'(ic);
    ifm_row = f; wgt_row = w;
    for (int b = 0; b < nb; b++) begin
      drive_beat(wt);
      if (b == 0) begin
        stride = ~st; relu_en = ~rl; cfg_ic = ~ICW'(ic);
      end
    end
    in_valid = 0;
  endtask

  task automatic wait_out();
    logic done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (out_valid && out_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL out_timeout: got no output, want output");
    end
  endtask

  task automatic test_reset();
    logic seen;
    rstn = 0; in_valid = 1; out_ready = 1;
    stride = 0; relu_en = 0; cfg_ic = '0;
    ifm_row = ifm_const(1); wgt_row = wgt_const(1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b, want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b, want 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL rst_out_data: got %h, want 0", out_data);
    end
    in_valid = 0;
    rstn = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL idle_output: got 1, want 0");
    end
  endtask

  task automatic test_back_to_back();
    run_job(0, 0, 0, ifm_const(1), wgt_const(1));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid: got %b, want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL out_rise: got %b, want 1", out_valid);
    end
    wait_out();
  endtask

  task automatic test_stride();
    run_job(1, 0, 0, ifm_ramp(), wgt_const(1));
    wait_out();
    run_job(0, 0, 0, ifm_ramp(), wgt_const(1));
    wait_out();
  endtask

  task automatic test_signed();
    run_job(0, 0, 1, ifm_const(-128), wgt_const(-128));
    wait_out();
    run_job(0, 0, 1, ifm_const(-128), wgt_const(127));
    wait_out();
    run_job(0, 1, 1, ifm_const(-128), wgt_const(127));
    wait_out();
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] snap;
    int wt;
    out_ready = 0;
    run_job(0, 0, 0, ifm_const(1), wgt_const(1));
    stride = 0; relu_en = 0; cfg_ic = '0;
    in_valid = 1;
    @(posedge clk); #1;
    snap = out_data;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== snap) begin
        errors++;
        $display("FAIL hold: got rdy=%b vld=%b data=%h, want 0 1 %h",
                 in_ready, out_valid, out_data, snap);
      end
    end
    exp_q.push_back(model(0, 0, K, ifm_const(1), wgt_const(1)));
    out_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_hs: got rdy=%b vld=%b, want 1 0",
               in_ready, out_valid);
    end
    for (int b = 0; b < K; b++) begin
      drive_beat(wt);
      if (b == 0) begin
        checks++;
        if (wt != 0) begin
          errors++;
          $display("FAIL next_accept: got wait %0d, want 0", wt);
        end
      end
    end
    in_valid = 0;
    wait_out();
  endtask

  task automatic test_reset_midjob();
    logic seen;
    int wt;
    stride = 0; relu_en = 0; cfg_ic = '0;
    ifm_row = ifm_const(5); wgt_row = wgt_const(3);
    drive_beat(wt);
    drive_beat(wt);
    in_valid = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL aborted_output: got 1, want 0");
    end
    run_job(0, 0, 0, ifm_const(1), wgt_const(1));
    wait_out();
  endtask

  task automatic test_max_channels();
    run_job(0, 0, (1 << ICW) - 1, ifm_const(1), wgt_const(1));
    wait_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stride();
    test_signed();
    test_backpressure();
    test_reset_midjob();
    test_max_channels();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
